// File: rtl/ct_f_spsram_256x54_ctrl_pkg.sv
// Shared types and constants for the 256x54 single-port SRAM access controller.
package ct_f_spsram_256x54_ctrl_pkg;

   localparam int unsigned ADDR_WIDTH_DFLT = 8;
   localparam int unsigned DATA_WIDTH_DFLT = 54;

   // Per-bit WEN level that leaves a word untouched (WEN is active low).
   localparam logic SRAM_WEN_IDLE_BIT = 1'b1;

   // Clear sweep in progress, or normal request service.
   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } sweep_state_e;

endpackage

// File: rtl/ct_f_spsram_256x54_ctrl_if.sv
// Requester and SRAM-side signal bundle of the 256x54 SRAM access controller.
interface ct_f_spsram_256x54_ctrl_if
   import ct_f_spsram_256x54_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DFLT,
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DFLT
);

   logic                  flush_req;
   logic                  init_done;

   logic                  wr_vld;
   logic                  wr_rdy;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [DATA_WIDTH-1:0] wr_bwe;

   logic                  rd_vld;
   logic                  rd_rdy;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic                  rd_data_vld;
   logic [DATA_WIDTH-1:0] rd_data;

   logic [ADDR_WIDTH-1:0] sram_a;
   logic                  sram_cen;
   logic                  sram_gwen;
   logic [DATA_WIDTH-1:0] sram_wen;
   logic [DATA_WIDTH-1:0] sram_d;
   logic [DATA_WIDTH-1:0] sram_q;

   // Controller side.
   modport slave (
      input  flush_req, wr_vld, wr_addr, wr_data, wr_bwe, rd_vld, rd_addr, sram_q,
      output init_done, wr_rdy, rd_rdy, rd_data_vld, rd_data,
             sram_a, sram_cen, sram_gwen, sram_wen, sram_d
   );

   // Requesting pipeline plus SRAM macro side.
   modport master (
      output flush_req, wr_vld, wr_addr, wr_data, wr_bwe, rd_vld, rd_addr, sram_q,
      input  init_done, wr_rdy, rd_rdy, rd_data_vld, rd_data,
             sram_a, sram_cen, sram_gwen, sram_wen, sram_d
   );

endinterface

// File: rtl/ct_f_spsram_init_sweep.sv
// INIT/RUN state and clear-sweep address counter for the SRAM access controller.
module ct_f_spsram_init_sweep
   import ct_f_spsram_256x54_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DFLT
) (
   input  logic                  forever_cpuclk,
   input  logic                  cpurst_b,
   input  logic                  flush_req,
   output logic                  sweep_active,
   output logic [ADDR_WIDTH-1:0] sweep_addr
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

   sweep_state_e          state;
   logic [ADDR_WIDTH-1:0] cnt;

   // Walk every address once in INIT; a flush in RUN restarts the walk from 0.
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         state <= ST_INIT;
         cnt   <= '0;
      end else begin
         case (state)
            ST_INIT: begin
               if (cnt == LAST_ADDR) begin
                  state <= ST_RUN;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + ADDR_WIDTH'(1);
               end
            end
            ST_RUN: begin
               if (flush_req) begin
                  state <= ST_INIT;
                  cnt   <= '0;
               end
            end
            default: begin
               state <= ST_INIT;
               cnt   <= '0;
            end
         endcase
      end
   end

   assign sweep_active = (state == ST_INIT);
   assign sweep_addr   = cnt;

endmodule

// File: rtl/ct_f_spsram_256x54_ctrl.sv
// Access controller in front of the 256x54 single-port SRAM: clear sweep,
// write-priority arbitration, SRAM pin drive and read return with hold.
module ct_f_spsram_256x54_ctrl
   import ct_f_spsram_256x54_ctrl_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH = ADDR_WIDTH_DFLT,
   parameter int unsigned           DATA_WIDTH = DATA_WIDTH_DFLT,
   parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
   input logic                      forever_cpuclk,
   input logic                      cpurst_b,
   ct_f_spsram_256x54_ctrl_if.slave bus
);

   localparam logic [DATA_WIDTH-1:0] WEN_IDLE = {DATA_WIDTH{SRAM_WEN_IDLE_BIT}};

   logic                  sweep_active;
   logic [ADDR_WIDTH-1:0] sweep_addr;

   logic                  wr_rdy_c;
   logic                  rd_rdy_c;
   logic                  wr_acc_c;
   logic                  rd_acc_c;

   logic [ADDR_WIDTH-1:0] sram_a_c;
   logic                  sram_cen_c;
   logic                  sram_gwen_c;
   logic [DATA_WIDTH-1:0] sram_wen_c;
   logic [DATA_WIDTH-1:0] sram_d_c;
   logic [ADDR_WIDTH-1:0] last_a;

   logic                  rd_pend;
   logic [DATA_WIDTH-1:0] rd_hold;

   ct_f_spsram_init_sweep #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_sweep (
      .forever_cpuclk (forever_cpuclk),
      .cpurst_b       (cpurst_b),
      .flush_req      (bus.flush_req),
      .sweep_active   (sweep_active),
      .sweep_addr     (sweep_addr)
   );

   // Handshakes: nothing during the sweep or a flush cycle; a write wins over a read.
   always_comb begin
      wr_rdy_c = 1'b0;
      rd_rdy_c = 1'b0;
      if (!sweep_active) begin
         wr_rdy_c = !bus.flush_req;
         rd_rdy_c = !bus.flush_req && !bus.wr_vld;
      end
      wr_acc_c = bus.wr_vld && wr_rdy_c;
      rd_acc_c = bus.rd_vld && rd_rdy_c;
   end

   // SRAM pin drive: sweep write, requester write, read, or idle parked on the last address.
   always_comb begin
      sram_a_c    = last_a;
      sram_cen_c  = 1'b1;
      sram_gwen_c = 1'b1;
      sram_wen_c  = WEN_IDLE;
      sram_d_c    = '0;
      if (sweep_active) begin
         sram_a_c    = sweep_addr;
         sram_cen_c  = 1'b0;
         sram_gwen_c = 1'b0;
         sram_wen_c  = '0;
         sram_d_c    = INIT_VAL;
      end else if (wr_acc_c) begin
         sram_a_c    = bus.wr_addr;
         sram_cen_c  = 1'b0;
         sram_gwen_c = 1'b0;
         sram_wen_c  = ~bus.wr_bwe;
         sram_d_c    = bus.wr_data;
      end else if (rd_acc_c) begin
         sram_a_c    = bus.rd_addr;
         sram_cen_c  = 1'b0;
      end
   end

   // Remember the address on the pins so an idle cycle keeps A stable.
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         last_a <= '0;
      end else begin
         last_a <= sram_a_c;
      end
   end

   // Read return: Q is valid the cycle after the accept; capture it for holding.
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         rd_pend <= 1'b0;
         rd_hold <= '0;
      end else begin
         rd_pend <= rd_acc_c;
         if (rd_pend) begin
            rd_hold <= bus.sram_q;
         end
      end
   end

   assign bus.init_done   = !sweep_active;
   assign bus.wr_rdy      = wr_rdy_c;
   assign bus.rd_rdy      = rd_rdy_c;
   assign bus.rd_data_vld = rd_pend;
   assign bus.rd_data     = rd_pend ? bus.sram_q : rd_hold;

   assign bus.sram_a      = sram_a_c;
   assign bus.sram_cen    = sram_cen_c;
   assign bus.sram_gwen   = sram_gwen_c;
   assign bus.sram_wen    = sram_wen_c;
   assign bus.sram_d      = sram_d_c;

endmodule

// File: tb/tb_ct_f_spsram_256x54_ctrl.sv
// Scoreboard bench for the 256x54 SRAM access controller with a behavioural SRAM.
module tb_ct_f_spsram_256x54_ctrl;

   localparam int unsigned AW = 8;
   localparam int unsigned DW = 54;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   ct_f_spsram_256x54_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   ct_f_spsram_256x54_ctrl #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .INIT_VAL   ('0)
   ) dut (
      .forever_cpuclk (clk),
      .cpurst_b       (rst_n),
      .bus            (bus)
   );

   // Behavioural SRAM: bit-masked write, registered read data.
   logic [DW-1:0] mem [256];
   logic [DW-1:0] q;

   always @(posedge clk) begin
      if (!bus.sram_cen) begin
         if (!bus.sram_gwen)
            mem[bus.sram_a] <= (mem[bus.sram_a] & bus.sram_wen) | (bus.sram_d & ~bus.sram_wen);
         else
            q <= mem[bus.sram_a];
      end
   end

   assign bus.sram_q = q;

   int            tests = 0;
   int            fails = 0;
   logic [DW-1:0] exp_q [$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every read-data pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && bus.rd_data_vld === 1'b1) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL rd_unexpected: got pulse with %h expected no pulse at %0t", bus.rd_data, $time);
         end else begin
            check("rd_data", 64'(bus.rd_data), 64'(exp_q.pop_front()));
         end
      end
   end

   task automatic idle();
      bus.wr_vld = 1'b0;
      bus.rd_vld = 1'b0;
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Called at posedge+1; returns at posedge+1 just after the accepting edge.
   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] be);
      int n = 0;
      bus.rd_vld  = 1'b0;
      bus.wr_vld  = 1'b1;
      bus.wr_addr = a;
      bus.wr_data = d;
      bus.wr_bwe  = be;
      #1;
      while (bus.wr_rdy !== 1'b1 && n < 300) begin
         @(posedge clk);
         #2;
         n++;
      end
      if (n >= 300) begin
         tests++;
         fails++;
         $display("FAIL wr_timeout: got no wr_rdy expected wr_rdy within 300 cycles");
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] e);
      int n = 0;
      bus.wr_vld  = 1'b0;
      bus.rd_vld  = 1'b1;
      bus.rd_addr = a;
      #1;
      while (bus.rd_rdy !== 1'b1 && n < 300) begin
         @(posedge clk);
         #2;
         n++;
      end
      if (n >= 300) begin
         tests++;
         fails++;
         $display("FAIL rd_timeout: got no rd_rdy expected rd_rdy within 300 cycles");
      end
      @(posedge clk);
      exp_q.push_back(e);
      #1;
   endtask

   // Entered just after the sweep starts at counter 0; requests held high must stay stalled.
   task automatic check_sweep(input string tag, input logic exp_wr_rdy);
      bus.wr_vld = 1'b1;
      bus.rd_vld = 1'b1;
      #1;
      for (int i = 0; i < 256; i++) begin
         check({tag, "_a"}, 64'(bus.sram_a), 64'(i));
         check({tag, "_ctl"}, 64'({bus.sram_cen, bus.sram_gwen, bus.init_done, bus.wr_rdy, bus.rd_rdy}), 64'd0);
         check({tag, "_wen_d"}, 64'(bus.sram_wen | bus.sram_d), 64'd0);
         @(posedge clk);
         #1;
      end
      check({tag, "_done"}, 64'(bus.init_done), 64'd1);
      check({tag, "_wr_rdy"}, 64'(bus.wr_rdy), 64'(exp_wr_rdy));
      check({tag, "_rd_rdy"}, 64'(bus.rd_rdy), 64'd0);
      bus.wr_vld = 1'b0;
      bus.rd_vld = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000 ns");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst_n         = 1'b0;
      bus.flush_req = 1'b0;
      bus.wr_vld    = 1'b0;
      bus.wr_addr   = '0;
      bus.wr_data   = '0;
      bus.wr_bwe    = '0;
      bus.rd_vld    = 1'b0;
      bus.rd_addr   = '0;

      // Reset state.
      cyc(3);
      check("rst_init_done", 64'(bus.init_done), 64'd0);
      check("rst_rd_vld", 64'(bus.rd_data_vld), 64'd0);
      check("rst_rd_data", 64'(bus.rd_data), 64'd0);
      check("rst_cen", 64'(bus.sram_cen), 64'd0);
      check("rst_a", 64'(bus.sram_a), 64'd0);
      check("rst_wen", 64'(bus.sram_wen), 64'd0);

      // 1: sweep after reset release.
      @(negedge clk);
      rst_n = 1'b1;
      check_sweep("sweep0", 1'b1);

      // 2: full write then read-after-write, held after the pulse.
      do_write(8'h12, 54'h2A_5A5A_5A5A_5A5A, '1);
      do_read(8'h12, 54'h2A_5A5A_5A5A_5A5A);
      idle();
      cyc(3);
      check("hold_data", 64'(bus.rd_data), 64'h2A_5A5A_5A5A_5A5A);
      check("hold_vld", 64'(bus.rd_data_vld), 64'd0);

      // 3: masked write merges, zero mask preserves everything.
      do_write(8'h12, 54'h3F_FFFF_FFFF_FFFF, 54'h3F_FFFF_0000_0000);
      do_read(8'h12, 54'h3F_FFFF_5A5A_5A5A);
      do_write(8'h12, 54'h0, 54'h0);
      do_read(8'h12, 54'h3F_FFFF_5A5A_5A5A);
      idle();
      cyc(2);

      // 4: collision -- write wins, read stalls one cycle.
      do_write(8'h02, 54'h15_1234_5678_9ABC, '1);
      bus.wr_vld  = 1'b1;
      bus.wr_addr = 8'h01;
      bus.wr_data = 54'h0A_BCDE_F012_3456;
      bus.wr_bwe  = '1;
      bus.rd_vld  = 1'b1;
      bus.rd_addr = 8'h02;
      #1;
      check("coll_wr_rdy", 64'(bus.wr_rdy), 64'd1);
      check("coll_rd_rdy", 64'(bus.rd_rdy), 64'd0);
      @(posedge clk);
      #1;
      bus.wr_vld = 1'b0;
      #1;
      check("coll_rd_rdy2", 64'(bus.rd_rdy), 64'd1);
      @(posedge clk);
      exp_q.push_back(54'h15_1234_5678_9ABC);
      #1;
      // Back-to-back reads, one pulse each.
      do_read(8'h01, 54'h0A_BCDE_F012_3456);
      do_read(8'h02, 54'h15_1234_5678_9ABC);
      do_read(8'h12, 54'h3F_FFFF_5A5A_5A5A);
      idle();
      #1;
      check("idle_a", 64'(bus.sram_a), 64'h12);
      check("idle_cen", 64'(bus.sram_cen), 64'd1);
      cyc(3);

      // 5: read then flush pulse; sweep clears contents.
      do_read(8'h12, 54'h3F_FFFF_5A5A_5A5A);
      bus.rd_vld    = 1'b0;
      bus.flush_req = 1'b1;
      bus.wr_vld    = 1'b1;
      #1;
      check("flush_init_done", 64'(bus.init_done), 64'd1);
      check("flush_wr_rdy", 64'(bus.wr_rdy), 64'd0);
      @(posedge clk);
      #1;
      bus.flush_req = 1'b0;
      check_sweep("sweep1", 1'b1);
      do_read(8'h12, 54'h0);
      do_read(8'h01, 54'h0);
      idle();
      cyc(2);

      // Held flush: one RUN cycle without accepts, then sweep again; reset mid-sweep.
      do_write(8'h05, 54'h2B_CDEF_0123_4567, '1);
      do_read(8'h05, 54'h2B_CDEF_0123_4567);
      idle();
      cyc(2);
      check("hold5", 64'(bus.rd_data), 64'h2B_CDEF_0123_4567);
      bus.flush_req = 1'b1;
      @(posedge clk);
      #1;
      check_sweep("sweep2", 1'b0);
      @(posedge clk);
      #1;
      check("reflush_done", 64'(bus.init_done), 64'd0);
      check("reflush_a", 64'(bus.sram_a), 64'd0);
      bus.flush_req = 1'b0;

      // 6: reset at sweep address 100.
      n = 0;
      while (bus.sram_a != 8'd100 && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("reach_100", 64'(bus.sram_a), 64'd100);
      rst_n = 1'b0;
      #1;
      check("mid_rst_a", 64'(bus.sram_a), 64'd0);
      check("mid_rst_done", 64'(bus.init_done), 64'd0);
      check("mid_rst_rd_data", 64'(bus.rd_data), 64'd0);
      check("mid_rst_rd_vld", 64'(bus.rd_data_vld), 64'd0);
      check("mid_rst_cen_d", 64'({bus.sram_cen, bus.sram_d}), 64'd0);
      cyc(2);
      @(negedge clk);
      rst_n = 1'b1;
      check_sweep("sweep3", 1'b1);
      idle();

      cyc(3);
      check("sb_empty", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
